sa_result_deskew: RTL and testbench

SA_RESULT_DESKEW -- requirements
Module: sa_result_deskew

---
 rtl/sa_result_deskew.sv | 138 +++++++++++++
 tb/tb_sa_result_deskew.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sa_result_deskew.sv
// Systolic-array result deskew: realigns the diagonal wavefront leaving the
// array bottom edge into whole rows and queues them behind a valid/ready port.

module sa_deskew_lane #(
  parameter int SW     = 32,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] din,
  output logic [SW-1:0] dout
);
  logic [STAGES-1:0][SW-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else begin
      sr[0] <= din;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[STAGES-1];
endmodule

module sa_result_deskew #(
  parameter int N     = 32,
  parameter int SW    = 32,
  parameter int DEPTH = 4,
  parameter int RW    = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RW-1:0]   num_rows,
  input  logic [N*SW-1:0] sa_col_out,
  output logic [N*SW-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_last,
  output logic            busy,
  output logic            done,
  output logic            overflow
);
  localparam int DW = N * SW;
  localparam int AW = $clog2(DEPTH);
  localparam logic [RW-1:0] N_RW    = RW'(N);
  localparam logic [RW-1:0] FILL_LD = RW'((N > 1) ? N - 2 : 0);

  typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DRAIN} state_t;

  logic [N-1:0][SW-1:0] row_al;

  // Column j is j cycles late, so it needs N-1-j stages to meet column N-1.
  for (genvar j = 0; j < N; j++) begin : g_lane
    if (j == N - 1) begin : g_pass
      assign row_al[j] = sa_col_out[SW*j +: SW];
    end else begin : g_dly
      sa_deskew_lane #(.SW(SW), .STAGES(N - 1 - j)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .din  (sa_col_out[SW*j +: SW]),
        .dout (row_al[j])
      );
    end
  end

  state_t        state;
  logic [RW-1:0] rows_q, cnt, wr_idx, rows_in;
  logic          ovf_q, start_ok, wr_en, wr_last;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;
  logic [DW:0]   mem [DEPTH];

  assign start_ok = start && (state == IDLE) && (num_rows != '0);
  assign rows_in  = (num_rows > N_RW) ? N_RW : num_rows;

  // The write fires one cycle ahead of the state it belongs to: row 0 aligns
  // in the last FILL cycle (or the start cycle itself when N is 1).
  assign wr_en   = (start_ok && (N == 1)) ||
                   ((state == FILL) && (cnt == '0)) ||
                   ((state == CAPTURE) && (wr_idx != rows_q));
  assign wr_last = (state == IDLE) ? (rows_in == RW'(1)) : (wr_idx == rows_q - RW'(1));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = res_valid && res_ready;
  assign push  = wr_en && (!full || pop);
  assign drop  = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rows_q <= '0;
      wr_idx <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (start_ok || wr_en)
        wr_idx <= start_ok ? RW'(N == 1) : wr_idx + RW'(1);
      if (start_ok)  ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      unique case (state)
        IDLE: if (start_ok) begin
          rows_q <= rows_in;
          cnt    <= (N == 1) ? '0 : FILL_LD;
          state  <= (N == 1) ? CAPTURE : FILL;
        end
        FILL: if (cnt == '0) state <= CAPTURE;
              else           cnt   <= cnt - RW'(1);
        CAPTURE: if (cnt == rows_q - RW'(1)) state <= DRAIN;
                 else                         cnt   <= cnt + RW'(1);
        DRAIN: if (empty) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_last, row_al};
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign res_valid            = !empty && !rst;
  assign {res_last, res_data} = res_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign busy                 = (state != IDLE) && !rst;
  assign done                 = (state == DRAIN) && empty && !rst;
  assign overflow             = ovf_q && !rst;
endmodule

// File: tb/tb_sa_result_deskew.sv
// Bench for sa_result_deskew: cycle-level reference model with a row
// scoreboard, a table of jobs, and hand sequences for reset and restart.

module tb_sa_result_deskew;
  localparam int N = 32, SW = 32, DEPTH = 4, RW = $clog2(N) + 1, DW = N * SW;

  logic          clk, rst, start, res_ready;
  logic [RW-1:0] num_rows;
  logic [DW-1:0] sa_col_out, res_data;
  logic          res_valid, res_last, busy, done, overflow;

  sa_result_deskew #(.N(N), .SW(SW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .sa_col_out(sa_col_out), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_last(res_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic last; } exp_t;
  typedef struct { int nr; bit acc; int mode; int hold; int restart_at; int exp_rows; int exp_ovf; } vec_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int job_t = -1000, job_rows = 0, m_occ = 0;
  logic [31:0] job_base = '0, next_base = '0;
  bit m_busy = 0, m_ovf = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  int rows_rx, done_cnt, done_cyc, first_vld, last_cyc;

  function automatic logic [SW-1:0] val(input logic [31:0] base, input int r, input int j);
    return base + 32'(100 * r + j);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic tick(input logic st, input int nr, input logic rdy, input logic rs);
    logic acc, wr, pop, exp_done;
    int r, bad;
    exp_t e;
    logic [DW-1:0] cols, erow;
    rst = rs; start = st; num_rows = RW'(nr); res_ready = rdy;
    acc = st && !rs && !m_busy && (nr != 0);
    if (acc) begin
      job_t = cyc; job_rows = (nr > N) ? N : nr; job_base = next_base;
    end
    for (int j = 0; j < N; j++) begin
      r = cyc - job_t - j;
      cols[SW*j +: SW] = (r >= 0 && r < job_rows) ? val(job_base, r, j) : SW'($urandom);
    end
    sa_col_out = cols;
    #1;
    if (rs) begin
      chk("rst_outputs", {res_valid, res_last, busy, done, overflow}, 5'b0);
      chk("rst_res_data_zero", 64'(res_data != '0), 64'd0);
      sb.delete(); m_occ = 0; m_busy = 0; m_ovf = 0; job_rows = 0; prev_stall = 0;
    end else begin
      exp_done = m_busy && (cyc >= job_t + N + job_rows) && (m_occ == 0);
      chk("res_valid", res_valid, m_occ != 0);
      chk("busy", busy, m_busy);
      chk("done", done, exp_done);
      chk("overflow", overflow, m_ovf);
      if (prev_stall) begin
        chk("hold_data", 64'(res_data !== prev_data), 64'd0);
        chk("hold_last", res_last, prev_last);
      end
      if (res_valid && first_vld < 0) first_vld = cyc;
      if (res_valid && rdy) begin
        if (sb.size() == 0) chk("unexpected_row", 1, 0);
        else begin
          e = sb.pop_front();
          bad = -1;
          for (int j = N - 1; j >= 0; j--) if (res_data[SW*j +: SW] !== e.d[SW*j +: SW]) bad = j;
          n_checks++;
          if (bad >= 0) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL res_data col %0d: got %0h expected %0h (cycle %0d)",
                                       bad, res_data[SW*bad +: SW], e.d[SW*bad +: SW], cyc);
          end
          chk("res_last", res_last, e.last);
          if (res_last) last_cyc = cyc;
          rows_rx++;
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      pop = (m_occ != 0) && rdy;
      r = cyc - job_t - (N - 1);
      wr = m_busy && r >= 0 && r < job_rows;
      if (wr) begin
        if (m_occ == DEPTH && !pop) m_ovf = 1;
        else begin
          for (int j = 0; j < N; j++) erow[SW*j +: SW] = val(job_base, r, j);
          sb.push_back('{erow, r == job_rows - 1});
          m_occ++;
        end
      end
      if (pop) m_occ--;
      if (exp_done) m_busy = 0;
      if (acc) begin m_busy = 1; m_ovf = 0; end
      prev_stall = res_valid && !rdy; prev_data = res_data; prev_last = res_last;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_job(input vec_t v);
    logic rdy;
    bit ended = 0;
    rows_rx = 0; done_cnt = 0; done_cyc = -1; first_vld = -1; last_cyc = -1;
    for (int off = 0; off < 400; off++) begin
      case (v.mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = (off >= v.hold);
        default: rdy = 1'b1;
      endcase
      tick((off == 0) || (off == v.restart_at), (off == 0) ? v.nr : 5, rdy, 1'b0);
      if (off >= 2 && !m_busy && m_occ == 0) begin ended = 1; break; end
    end
    n_checks++;
    if (!ended) begin n_fail++; $display("FAIL job_timeout: nr=%0d did not finish", v.nr); end
    if (v.exp_rows >= 0) chk("rows_received", rows_rx, v.exp_rows);
    chk("done_count", done_cnt, v.acc ? 1 : 0);
    if (v.exp_ovf >= 0) chk("overflow_end", overflow, v.exp_ovf[0]);
    chk("scoreboard_empty", sb.size(), 0);
    if (v.acc && v.mode == 0) begin
      chk("first_valid_lat", first_vld - job_t, N);
      chk("done_lat", done_cyc - job_t, N + job_rows);
      chk("last_lat", last_cyc - job_t, N + job_rows - 1);
    end
  endtask

  vec_t vt[10];

  initial begin
    //        nr acc mode hold rst_at rows ovf
    vt[0] = '{ 4, 1, 0,  0, -1,  4,  0};
    vt[1] = '{ 1, 1, 0,  0, -1,  1,  0};
    vt[2] = '{32, 1, 0,  0, -1, 32,  0};
    vt[3] = '{40, 1, 0,  0, -1, 32,  0};
    vt[4] = '{ 0, 0, 0,  0, -1,  0,  0};
    vt[5] = '{32, 1, 2, 64, -1,  4,  1};
    vt[6] = '{ 8, 1, 2, 35, -1,  8,  0};
    vt[7] = '{12, 1, 1,  0, -1, -1, -1};
    vt[8] = '{ 2, 1, 0,  0,  5,  2,  0};
    vt[9] = '{ 6, 1, 0,  0, -1,  6,  0};

    rst = 1'b1; start = 1'b0; num_rows = '0; res_ready = 1'b1; sa_col_out = '0;
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b1, 1'b1);

    // Reset in the middle of an 8-row job: job aborts silently.
    next_base = 32'hF000_0000;
    done_cnt = 0; rows_rx = 0; first_vld = -1;
    tick(1'b1, 8, 1'b1, 1'b0);
    for (int i = 1; i < 20; i++) tick(1'b0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 1'b1, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_valid", res_valid, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 0, 1'b1, 1'b0);
    chk("aborted_done_count", done_cnt, 0);
    chk("aborted_rows", rows_rx, 0);

    for (int i = 0; i < 10; i++) begin
      next_base = 32'(i) * 32'h1357_0000;
      run_job(vt[i]);
      for (int k = 0; k < 2; k++) tick(1'b0, 0, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
